// File: rtl/bus_trace_buffer_pkg.sv
// rtl/bus_trace_buffer_pkg.sv - shared state, trigger-mode and entry-layout definitions
package bus_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } trace_state_e;

  localparam logic [1:0] TM_ANY   = 2'b00;
  localparam logic [1:0] TM_READ  = 2'b01;
  localparam logic [1:0] TM_WRITE = 2'b10;
  localparam logic [1:0] TM_SYNC  = 2'b11;

  // Entry layout is {rw, sync, addr, data}, data in the low bits.
  function automatic int ent_data_lsb();
    return 0;
  endfunction

  function automatic int ent_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int ent_sync_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int ent_rw_bit(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port RAM, one write port, one registered read port
module trace_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int W     = 26
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Write port; contents are not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, only updated on a read request.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_trace_buffer.sv
// rtl/bus_trace_buffer.sv - triggered circular capture of CPU bus cycles with readout
module bus_trace_buffer
  import bus_trace_buffer_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 256,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int ENTRY_W = ADDR_W + DATA_W + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  data,
  input  logic               rw,
  input  logic               sync,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [ADDR_W-1:0]  trig_addr,
  input  logic [ADDR_W-1:0]  trig_addr_mask,
  input  logic [DATA_W-1:0]  trig_data,
  input  logic [DATA_W-1:0]  trig_data_mask,
  input  logic [1:0]         trig_mode,
  input  logic [IDX_W-1:0]   post_count,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic               busy,
  output logic               done,
  output logic               triggered,
  output logic [IDX_W:0]     fill_count,
  output logic [IDX_W-1:0]   trig_pos
);

  localparam logic [IDX_W:0]   FULL     = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] MAX_POST = IDX_W'(DEPTH - 1);

  trace_state_e     state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   fill_q, fill_d;
  logic [IDX_W-1:0] remaining_q, remaining_d;
  logic [IDX_W-1:0] trig_ptr_q, trig_ptr_d;
  logic             triggered_q, triggered_d;
  logic             force_lat_q, force_lat_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_zero_q, rd_zero_d;

  logic               ram_we;
  logic               ram_re;
  logic [IDX_W-1:0]   ram_raddr;
  logic [ENTRY_W-1:0] ram_wdata;
  logic [ENTRY_W-1:0] ram_rdata;
  logic [IDX_W-1:0]   oldest;
  logic               mode_ok;
  logic               hit;
  logic [IDX_W-1:0]   post_clamped;

  assign ram_wdata = {rw, sync, addr, data};
  assign oldest    = (fill_q == FULL) ? wr_ptr_q : '0;
  // Keeping post_count below DEPTH guarantees the trigger sample survives the post phase.
  assign post_clamped = (post_count > MAX_POST) ? MAX_POST : post_count;

  // Cycle-type qualifier and masked address/data compare for the trigger.
  always_comb begin
    mode_ok = 1'b1;
    case (trig_mode)
      TM_READ:  mode_ok = rw;
      TM_WRITE: mode_ok = ~rw;
      TM_SYNC:  mode_ok = sync;
      default:  mode_ok = 1'b1;
    endcase
    hit = force_lat_q | force_trig |
          ((((addr ^ trig_addr) & trig_addr_mask) == '0) &&
           (((data ^ trig_data) & trig_data_mask) == '0) && mode_ok);
  end

  // Capture FSM, write pointer, fill level and readout request handling.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    trig_ptr_d  = trig_ptr_q;
    triggered_d = triggered_q;
    force_lat_d = force_lat_q;
    rd_valid_d  = 1'b0;
    rd_zero_d   = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = oldest + rd_idx;

    if (arm) begin
      // Arm restarts capture from any state and swallows a coincident sample.
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      fill_d      = '0;
      remaining_d = '0;
      trig_ptr_d  = '0;
      triggered_d = 1'b0;
      force_lat_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (force_trig) force_lat_d = 1'b1;
          if (sample_en) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
            if (hit) begin
              triggered_d = 1'b1;
              force_lat_d = 1'b0;
              trig_ptr_d  = wr_ptr_q;
              remaining_d = post_clamped;
              state_d     = (post_clamped == '0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (sample_en) begin
            ram_we      = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            fill_d      = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == IDX_W'(1)) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end

    if (state_q == ST_DONE && rd_en) begin
      ram_re     = 1'b1;
      rd_valid_d = 1'b1;
      rd_zero_d  = ({1'b0, rd_idx} >= fill_q);
    end
  end

  // State and pointer registers; reset overrides any capture in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      trig_ptr_q  <= '0;
      triggered_q <= 1'b0;
      force_lat_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_zero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      trig_ptr_q  <= trig_ptr_d;
      triggered_q <= triggered_d;
      force_lat_q <= force_lat_d;
      rd_valid_q  <= rd_valid_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .W     (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // The RAM output is masked so out-of-range reads and idle cycles present zero.
  assign rd_entry   = (rd_valid_q && !rd_zero_q) ? ram_rdata : '0;
  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done       = (state_q == ST_DONE);
  assign triggered  = triggered_q;
  assign fill_count = fill_q;
  assign trig_pos   = triggered_q ? (trig_ptr_q - oldest) : '0;

endmodule
